twp_master: RTL and testbench
=============================

// Module: twp_master
// PURPOSE
//  Two-Wire Protocol (TWP) initiator: drives register write/read frames on SDA to a TWP slave register bank.
//  Sits between an on-chip command source (valid/ready) and the shared SDA line; returns read data and status.
//  Frames are bit-serial at one bit per clk, LSB first. The SDA line has an external pull-up, so a released line reads 1.
// PARAMETERS
//  TAR_TIMEOUT  8  max released cycles to wait for slave sync-low on a read before abort (>=3)
//  IDLE_GAP     1  cycles SDA held high after a frame before cmd_ready re-asserts (>=1)
// PORTS
//  clk         in     1   system clock; all logic on posedge
//  reset       in     1   synchronous, active-high reset
//  SDA         inout  1   TWP data line; driven when internal oe=1, else 1'bz
//  cmd_valid   in     1   command request
//  cmd_ready   out    1   master can accept command
//  cmd_write   in     1   1=write, 0=read
//  cmd_addr    in     8   register address
//  cmd_wdata   in     16  write data (ignored on read)
//  resp_valid  out    1   one-cycle pulse: frame finished
//  resp_rdata  out    16  read data (0 for writes/errors); held until next resp_valid
//  resp_err    out    1   read aborted (timeout or bad stop bit); valid with resp_valid
//  busy        out    1   frame in progress (= ~IDLE)
// BEHAVIOUR
//  Reset: oe=1, SDA=1, cmd_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, state=GAP with gap counter=IDLE_GAP.
//  Reset mid-frame aborts at once: no resp_valid; SDA=1 on next cycle. Any in-flight command is dropped.
//  Accept: cmd_valid&&cmd_ready on cycle T. cmd_addr, cmd_wdata and cmd_write are latched. cmd_ready=0 from T+1 until the frame completes.
//  SDA output is registered; bit times below are cycles when the value is on the line.
//  Write frame:
//    T+1   start = 0
//    T+2   cmd = 1
//    T+3..T+10   addr[0..7]
//    T+11..T+26  wdata[0..15]
//    T+27  SDA=1, resp_valid=1, resp_err=0, resp_rdata=0
//  Read frame:
//    T+1 start = 0; T+2 cmd = 0; T+3..T+10 addr[0..7].
//    T+11: oe=0 (released). The master samples SDA each cycle; 1 or z counts as 1.
//    Sync = first sampled 0. The next 16 samples are rdata[0..15]. The following sample is the stop bit, which must be 1.
//    After the stop sample, the master waits one more released cycle (the slave releases), then sets oe=1 and SDA=1.
//    resp_valid fires in that same cycle, with resp_rdata = collected bits and resp_err = ~stop.
//    Timeout: if no 0 is sampled within TAR_TIMEOUT released cycles, the frame aborts.
//    On timeout: oe=1, SDA=1, resp_valid=1, resp_err=1, resp_rdata=0.
//  States: IDLE -> START -> CMD -> ADDR(8) -> {WDATA(16) | TAR_WAIT -> RDATA(16) -> STOP -> RELEASE} -> GAP -> IDLE.
//    TAR_WAIT -> GAP on timeout.
//  GAP: SDA=1 for IDLE_GAP cycles, then IDLE with cmd_ready=1. cmd_ready=1 only in IDLE.
//  Bit counter: 4-bit, wraps 7->0 at ADDR exit and 15->0 at data exit. Timeout counter: clog2(TAR_TIMEOUT+1) bits.
//  cmd_valid while not ready: ignored (no queueing). Inputs change mid-frame: no effect (latched at accept).
//  In IDLE the master always drives SDA=1 and never releases the line outside a read turnaround.
// TESTING
//  Bench: tri1 SDA with a behavioural slave. Reads use 1 cycle released, then 1,0,d0..d15,1, then release.
//  1 Write addr=0x5A data=0xBEEF -> SDA T+1..T+26 = 0,1,0,1,0,1,1,0,1,0, then 0xBEEF LSB first; SDA=1 and resp_valid/err=0 at T+27.
//  2 Read addr=0x03, slave returns 0x1234 -> addr bits 1,1,0,0,0,0,0,0; oe=0 at T+11; resp_rdata=0x1234, resp_err=0.
//  3 Read with slave silent -> resp_valid with err=1 and rdata=0 exactly TAR_TIMEOUT released cycles after T+11; SDA=1 again.
//  4 Read where slave drives stop=0 -> resp_err=1, resp_rdata=collected data.
//  5 reset=1 at T+15 of a write -> next cycle SDA=1, no resp_valid, cmd_ready after IDLE_GAP; next write completes normally.
//  6 Back-to-back: cmd_valid held high with two writes -> second accepted IDLE_GAP+1 cycles after first resp_valid; no SDA glitch to 0 in gap.

Source files
------------

// File: rtl/twp_master_if.sv
// Command/response interface for the TWP initiator.
// The master modport faces the TWP master. The slave modport faces the on-chip
// command source that feeds it.
interface twp_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/twp_master.sv
// TWP initiator: serialises register write/read frames onto SDA, LSB first,
// one bit per clk. During a read it releases SDA for the slave's reply.
// SDA has an external pull-up, so a released line reads back as 1.
module twp_master #(
  parameter int TAR_TIMEOUT = 8,
  parameter int IDLE_GAP    = 1
) (
  input  logic          clk,
  input  logic          reset,
  inout  wire           SDA,
  twp_master_if.master  bus
);

  localparam int TW = $clog2(TAR_TIMEOUT + 1);
  localparam int GW = $clog2(IDLE_GAP + 1);

  typedef enum logic [3:0] {
    IDLE, START, CMD, ADDR, WDATA, TAR_WAIT, RDATA, STOP, RELEASE, GAP
  } state_t;

  state_t        state;
  logic          oe;
  logic          sda_out;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic          lat_write;
  logic [7:0]    lat_addr;
  logic [15:0]   lat_wdata;
  logic [15:0]   shift;
  logic          stop_ok;
  logic          sda_low;

  // SDA is driven only while oe is high. Otherwise the pull-up or the slave owns the line.
  // Only a solid 0 counts as low, so a floating line is read as 1.
  assign SDA     = oe ? sda_out : 1'bz;
  assign sda_low = (SDA == 1'b0);

  // Frame sequencer. Every output is registered, and the state names the bit on the line this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= GAP;
      gap_cnt        <= GW'(IDLE_GAP);
      oe             <= 1'b1;
      sda_out        <= 1'b1;
      bit_cnt        <= 4'd0;
      tmo_cnt        <= '0;
      lat_write      <= 1'b0;
      lat_addr       <= 8'h00;
      lat_wdata      <= 16'h0000;
      shift          <= 16'h0000;
      stop_ok        <= 1'b0;
      bus.cmd_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 16'h0000;
      bus.resp_err   <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          oe      <= 1'b1;
          sda_out <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            lat_write     <= bus.cmd_write;
            lat_addr      <= bus.cmd_addr;
            lat_wdata     <= bus.cmd_wdata;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            sda_out       <= 1'b0;
            state         <= START;
          end
        end
        START: begin
          sda_out <= lat_write;
          state   <= CMD;
        end
        CMD: begin
          sda_out <= lat_addr[0];
          bit_cnt <= 4'd0;
          state   <= ADDR;
        end
        ADDR: begin
          if (bit_cnt == 4'd7) begin
            bit_cnt <= 4'd0;
            if (lat_write) begin
              sda_out <= lat_wdata[0];
              state   <= WDATA;
            end else begin
              oe      <= 1'b0;
              sda_out <= 1'b1;
              tmo_cnt <= '0;
              state   <= TAR_WAIT;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            sda_out <= lat_addr[bit_cnt[2:0] + 3'd1];
          end
        end
        WDATA: begin
          if (bit_cnt == 4'd15) begin
            bit_cnt        <= 4'd0;
            oe             <= 1'b1;
            sda_out        <= 1'b1;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= 16'h0000;
            bus.resp_err   <= 1'b0;
            bus.busy       <= 1'b0;
            gap_cnt        <= GW'(IDLE_GAP);
            state          <= GAP;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            sda_out <= lat_wdata[bit_cnt + 4'd1];
          end
        end
        TAR_WAIT: begin
          if (sda_low) begin
            bit_cnt <= 4'd0;
            state   <= RDATA;
          end else if (tmo_cnt == TW'(TAR_TIMEOUT - 1)) begin
            oe             <= 1'b1;
            sda_out        <= 1'b1;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= 16'h0000;
            bus.resp_err   <= 1'b1;
            bus.busy       <= 1'b0;
            gap_cnt        <= GW'(IDLE_GAP);
            state          <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RDATA: begin
          shift <= {~sda_low, shift[15:1]};
          if (bit_cnt == 4'd15) begin
            bit_cnt <= 4'd0;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        STOP: begin
          stop_ok <= ~sda_low;
          state   <= RELEASE;
        end
        RELEASE: begin
          oe             <= 1'b1;
          sda_out        <= 1'b1;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= shift;
          bus.resp_err   <= ~stop_ok;
          bus.busy       <= 1'b0;
          gap_cnt        <= GW'(IDLE_GAP);
          state          <= GAP;
        end
        GAP: begin
          oe      <= 1'b1;
          sda_out <= 1'b1;
          if (gap_cnt == '0) begin
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          oe            <= 1'b1;
          sda_out       <= 1'b1;
          bus.cmd_ready <= 1'b0;
          bus.busy      <= 1'b0;
          gap_cnt       <= GW'(IDLE_GAP);
          state         <= GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twp_master.sv
// Directed bench for twp_master. It drives a table of write/read frames,
// with a behavioural slave on a pulled-up SDA. Reset abort and back-to-back
// commands are covered by hand-written sequences.
module tb_twp_master;

  localparam int TAR_TIMEOUT = 8;
  localparam int IDLE_GAP    = 1;

  // Slave reply modes: 0 normal, 1 silent, 2 bad stop bit
  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          mode;
    logic [15:0] sdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_k;
  } vec_t;

  logic clk;
  logic reset;
  tri1  SDA;
  logic slv_oe;
  logic slv_val;

  logic        pend_valid;
  logic        pend_write;
  logic [7:0]  pend_addr;
  logic [15:0] pend_wdata;

  int checks;
  int errors;

  twp_master_if bus ();

  twp_master #(.TAR_TIMEOUT(TAR_TIMEOUT), .IDLE_GAP(IDLE_GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .SDA   (SDA),
    .bus   (bus)
  );

  // The behavioural slave drives the line only while it owns the turnaround.
  assign SDA = slv_oe ? slv_val : 1'bz;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Follows one accepted frame, starting from the negedge of the accept cycle T.
  // It returns at the negedge of the cycle where resp_valid is seen.
  task automatic monitorFrame(input vec_t v, input int idx);
    logic [25:0] bits;
    int          resp_k;
    logic [15:0] rd;
    logic        er;
    logic        sda_r;
    logic [25:0] exp_bits;
    bits   = '0;
    resp_k = -1;
    rd     = '0;
    er     = 1'b0;
    sda_r  = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput($sformatf("v%0d_ready_low", idx), 32'(bus.cmd_ready), 32'd0);
        checkOutput($sformatf("v%0d_busy", idx), 32'(bus.busy), 32'd1);
        bus.cmd_valid = pend_valid;
        bus.cmd_write = pend_write;
        bus.cmd_addr  = pend_addr;
        bus.cmd_wdata = pend_wdata;
      end
      if (k <= 26) bits[k-1] = SDA;
      if (!v.write && k == 11)
        checkOutput($sformatf("v%0d_released", idx), 32'(dut.oe), 32'd0);
      if (bus.resp_valid) begin
        resp_k = k;
        rd     = bus.resp_rdata;
        er     = bus.resp_err;
        sda_r  = SDA;
        break;
      end
      if (!v.write && v.mode != 1) begin
        slv_oe = 1'b0;
        if (k == 12)      begin slv_oe = 1'b1; slv_val = 1'b1; end
        else if (k == 13) begin slv_oe = 1'b1; slv_val = 1'b0; end
        else if (k >= 14 && k <= 29) begin slv_oe = 1'b1; slv_val = v.sdata[k-14]; end
        else if (k == 30) begin slv_oe = 1'b1; slv_val = (v.mode == 2) ? 1'b0 : 1'b1; end
      end
    end
    slv_oe = 1'b0;
    checkOutput($sformatf("v%0d_resp_cycle", idx), 32'(resp_k), 32'(v.exp_k));
    checkOutput($sformatf("v%0d_rdata", idx), 32'(rd), 32'(v.exp_rdata));
    checkOutput($sformatf("v%0d_err", idx), 32'(er), 32'(v.exp_err));
    checkOutput($sformatf("v%0d_sda_at_resp", idx), 32'(sda_r), 32'd1);
    if (v.write) begin
      exp_bits = {v.wdata, v.addr, 1'b1, 1'b0};
      checkOutput($sformatf("v%0d_wr_bits", idx), 32'(bits), 32'(exp_bits));
    end else begin
      exp_bits = {16'h0000, v.addr, 1'b0, 1'b0};
      checkOutput($sformatf("v%0d_rd_hdr", idx), 32'(bits[9:0]), 32'(exp_bits[9:0]));
    end
  endtask

  // Waits for cmd_ready and issues one command. Must be called at a negedge.
  task automatic applyStimulus(input vec_t v, input int idx);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checkOutput($sformatf("v%0d_ready_wait", idx), 32'd0, 32'd1);
    end else begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = v.write;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      pend_valid    = 1'b0;
      pend_write    = 1'b0;
      pend_addr     = 8'h00;
      pend_wdata    = 16'h0000;
      monitorFrame(v, idx);
    end
  endtask

  // Main test sequence
  initial begin
    vec_t tbl[6];
    vec_t va;
    vec_t vb;
    int   resp_gap;
    bit   got;
    bit   seen_resp;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    slv_oe = 1'b0;
    slv_val = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 16'h0000;
    pend_valid = 1'b0;
    pend_write = 1'b0;
    pend_addr  = 8'h00;
    pend_wdata = 16'h0000;

    //          write addr   wdata    mode sdata    rdata    err  k
    tbl[0] = '{1'b1, 8'h5A, 16'hBEEF, 0, 16'h0000, 16'h0000, 1'b0, 27};
    tbl[1] = '{1'b0, 8'h03, 16'h0000, 0, 16'h1234, 16'h1234, 1'b0, 32};
    tbl[2] = '{1'b0, 8'h03, 16'h0000, 1, 16'h0000, 16'h0000, 1'b1, 19};
    tbl[3] = '{1'b0, 8'hC1, 16'h0000, 2, 16'hA5C3, 16'hA5C3, 1'b1, 32};
    tbl[4] = '{1'b1, 8'hFF, 16'h0001, 0, 16'h0000, 16'h0000, 1'b0, 27};
    tbl[5] = '{1'b0, 8'h80, 16'hFFFF, 0, 16'h0000, 16'h0000, 1'b0, 32};

    repeat (3) @(negedge clk);
    checkOutput("rst_sda", 32'(SDA), 32'd1);
    checkOutput("rst_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_rdata", 32'(bus.resp_rdata), 32'd0);
    checkOutput("rst_err", 32'(bus.resp_err), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) applyStimulus(tbl[i], i);

    // Reset in the middle of a write aborts the frame silently
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.cmd_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("rstmid_ready_wait", 32'(got), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 16'h0000;
    seen_resp = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) bus.cmd_valid = 1'b0;
      if (bus.resp_valid) seen_resp = 1'b1;
      if (k == 15) reset = 1'b1;
      if (k == 16) begin
        reset = 1'b0;
        checkOutput("rstmid_sda", 32'(SDA), 32'd1);
        checkOutput("rstmid_busy", 32'(bus.busy), 32'd0);
      end
      if (k == 17) checkOutput("rstmid_ready_gap", 32'(bus.cmd_ready), 32'd0);
      if (k == 18) checkOutput("rstmid_ready", 32'(bus.cmd_ready), 32'd1);
    end
    checkOutput("rstmid_no_resp", 32'(seen_resp), 32'd0);
    applyStimulus(tbl[0], 6);

    // Two writes back-to-back with cmd_valid held high across the gap.
    // Changing the inputs mid-frame must not disturb the first frame.
    va = '{1'b1, 8'h3C, 16'h8001, 0, 16'h0000, 16'h0000, 1'b0, 27};
    vb = '{1'b1, 8'hA5, 16'h7E18, 0, 16'h0000, 16'h0000, 1'b0, 27};
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.cmd_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("b2b_ready_wait", 32'(got), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = va.write;
    bus.cmd_addr  = va.addr;
    bus.cmd_wdata = va.wdata;
    pend_valid = 1'b1;
    pend_write = vb.write;
    pend_addr  = vb.addr;
    pend_wdata = vb.wdata;
    monitorFrame(va, 7);
    resp_gap = -1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_gap_sda_%0d", j), 32'(SDA), 32'd1);
      if (j == 1) checkOutput("b2b_pulse", 32'(bus.resp_valid), 32'd0);
      if (bus.cmd_ready) begin
        resp_gap = j;
        break;
      end
    end
    checkOutput("b2b_accept_gap", 32'(resp_gap), 32'(IDLE_GAP + 1));
    pend_valid = 1'b0;
    pend_write = 1'b0;
    pend_addr  = 8'h00;
    pend_wdata = 16'h0000;
    monitorFrame(vb, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
